// File: rtl/ttl_pulse_driver.sv
//==============================================================================
// ttl_pulse_driver
//------------------------------------------------------------------------------
// Consumes the matched word from the real-time output core and drives 8 TTL
// lines. Each strobe's 64-bit command can do two things per channel: write a
// level, or start a self-terminating pulse. A pulse restores the channel's
// previous level after pulse_width cycles. The block also captures the first
// command that overrode a running pulse, and counts accepted strobes.
//
// Command layout (rto_out[63:0]):
//   [7:0] level   [15:8] write_mask   [23:16] pulse_mask   [39:24] pulse_width
//   [63:40] reserved; rto_out[127:64] timestamp (kept only in error capture)
//
// Ports:
//   clk                  system clock
//   reset                asynchronous active-low reset
//   flush                synchronous clear of timers, outputs and error state
//   counter_matched      one-cycle command strobe, rto_out valid with it
//   rto_out[127:0]       matched word
//   ttl_out[NUM_CH-1:0]  TTL line levels
//   busy                 at least one channel is pulsing
//   override_error       sticky: a command hit a channel mid-pulse
//   override_error_data  word that caused the first override since clear
//   command_count[31:0]  accepted strobes (wraps)
//
// Optional build macro: TTL_OUTPUT_RETIME_EN adds one output register stage
// on ttl_out (command-to-pin latency 2). busy and error outputs are not
// delayed.
//
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module ttl_pulse_driver #(
  parameter int                NUM_CH     = 8,
  parameter int                PW_BITS    = 16,
  parameter logic [NUM_CH-1:0] IDLE_LEVEL = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              counter_matched,
  input  logic [127:0]      rto_out,
  output logic [NUM_CH-1:0] ttl_out,
  output logic              busy,
  output logic              override_error,
  output logic [127:0]      override_error_data,
  output logic [31:0]       command_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } ch_state_e;

  // Command field decode
  logic [NUM_CH-1:0]  cmd_level;
  logic [NUM_CH-1:0]  cmd_write;
  logic [NUM_CH-1:0]  cmd_pulse;
  logic [PW_BITS-1:0] cmd_width;

  assign cmd_level = rto_out[0  +: NUM_CH];
  assign cmd_write = rto_out[8  +: NUM_CH];
  assign cmd_pulse = rto_out[16 +: NUM_CH];
  assign cmd_width = rto_out[24 +: PW_BITS];

  ch_state_e          state_q   [NUM_CH];
  ch_state_e          state_d   [NUM_CH];
  logic [PW_BITS-1:0] timer_q   [NUM_CH];
  logic [PW_BITS-1:0] timer_d   [NUM_CH];
  logic [NUM_CH-1:0]  chan_q,    chan_d;
  logic [NUM_CH-1:0]  restore_q, restore_d;
  logic               busy_q,    busy_d;
  logic               err_q,     err_d;
  logic [127:0]       errdat_q,  errdat_d;
  logic [31:0]        count_q,   count_d;
  logic               override_hit;

  always_comb begin
    chan_d       = chan_q;
    restore_d    = restore_q;
    err_d        = err_q;
    errdat_d     = errdat_q;
    count_d      = count_q;
    override_hit = 1'b0;
    busy_d       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
    end

    if (flush) begin
      // Flush wins over a simultaneous strobe; that strobe is not counted.
      chan_d   = IDLE_LEVEL;
      err_d    = 1'b0;
      errdat_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_d[i] = ST_IDLE;
        timer_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (counter_matched && cmd_write[i]) begin
          // A new write always wins, even on the pulse's final cycle.
          if (state_q[i] == ST_PULSE) begin
            override_hit = 1'b1;
          end
          chan_d[i] = cmd_level[i];
          if (cmd_pulse[i] && (cmd_width != '0)) begin
            restore_d[i] = chan_q[i];
            timer_d[i]   = cmd_width;
            state_d[i]   = ST_PULSE;
          end else begin
            timer_d[i]   = '0;
            state_d[i]   = ST_IDLE;
          end
        end else if (state_q[i] == ST_PULSE) begin
          // Loaded with W at the strobe edge, so restoring at timer==1
          // holds the pulse level for exactly W cycles.
          if (timer_q[i] == PW_BITS'(1)) begin
            chan_d[i]  = restore_q[i];
            timer_d[i] = '0;
            state_d[i] = ST_IDLE;
          end else begin
            timer_d[i] = timer_q[i] - PW_BITS'(1);
          end
        end
      end

      if (override_hit) begin
        err_d = 1'b1;
        if (!err_q) begin
          errdat_d = rto_out;
        end
      end

      if (counter_matched) begin
        count_d = count_q + 32'd1;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (state_d[i] == ST_PULSE) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chan_q    <= IDLE_LEVEL;
      restore_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      errdat_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      chan_q    <= chan_d;
      restore_q <= restore_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      errdat_q  <= errdat_d;
      count_q   <= count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

`ifdef TTL_OUTPUT_RETIME_EN
  // Pin-side register; it is cleared directly by flush so the pins go idle
  // on the same edge as the channel registers.
  logic [NUM_CH-1:0] pin_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin_q <= IDLE_LEVEL;
    end else if (flush) begin
      pin_q <= IDLE_LEVEL;
    end else begin
      pin_q <= chan_q;
    end
  end

  assign ttl_out = pin_q;
`else
  assign ttl_out = chan_q;
`endif

  assign busy                = busy_q;
  assign override_error      = err_q;
  assign override_error_data = errdat_q;
  assign command_count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_ttl_pulse_driver.sv
`default_nettype none
`timescale 1ns/1ps

module tb_ttl_pulse_driver;

`ifdef TTL_OUTPUT_RETIME_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif
  localparam int         LAT  = RET ? 2 : 1;
  localparam logic [7:0] IDLE = 8'h00;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         counter_matched;
  logic [127:0] rto_out;
  logic [7:0]   ttl_out;
  logic         busy;
  logic         override_error;
  logic [127:0] override_error_data;
  logic [31:0]  command_count;

  ttl_pulse_driver dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .counter_matched     (counter_matched),
    .rto_out             (rto_out),
    .ttl_out             (ttl_out),
    .busy                (busy),
    .override_error      (override_error),
    .override_error_data (override_error_data),
    .command_count       (command_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel remembers the absolute cycle at which its
  // pulse ends (or -1) and the level it returns to.
  int           cyc_n;
  logic [7:0]   m_ttl, m_pin, m_rest;
  int           m_end [8];
  logic         m_err;
  logic [127:0] m_data;
  logic [31:0]  m_cnt;

  task automatic model_reset();
    cyc_n  = 0;
    m_ttl  = IDLE;
    m_pin  = IDLE;
    m_rest = '0;
    m_err  = 1'b0;
    m_data = '0;
    m_cnt  = '0;
    for (int i = 0; i < 8; i++) m_end[i] = -1;
  endtask

  function automatic logic m_busy();
    for (int i = 0; i < 8; i++) if (m_end[i] >= 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input logic f, input logic s, input logic [127:0] w);
    logic [7:0] old;
    logic       ov;
    int         pw;
    cyc_n++;
    old = m_ttl;
    ov  = 1'b0;
    pw  = int'(w[39:24]);
    if (f) begin
      m_ttl  = IDLE;
      m_pin  = IDLE;
      m_err  = 1'b0;
      m_data = '0;
      for (int i = 0; i < 8; i++) m_end[i] = -1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s && w[8+i]) begin
          if (m_end[i] >= 0) ov = 1'b1;
          m_ttl[i] = w[i];
          if (w[16+i] && pw != 0) begin
            m_rest[i] = old[i];
            m_end[i]  = cyc_n + pw;
          end else begin
            m_end[i]  = -1;
          end
        end else if (m_end[i] == cyc_n) begin
          m_ttl[i] = m_rest[i];
          m_end[i] = -1;
        end
      end
      if (ov) begin
        if (!m_err) m_data = w;
        m_err = 1'b1;
      end
      if (s) m_cnt = m_cnt + 32'd1;
      m_pin = RET ? old : m_ttl;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ttl_out"}, 128'(ttl_out), 128'(m_pin));
    chk({tag, " busy"}, 128'(busy), 128'(m_busy()));
    chk({tag, " override_error"}, 128'(override_error), 128'(m_err));
    chk({tag, " override_error_data"}, override_error_data, m_data);
    chk({tag, " command_count"}, 128'(command_count), 128'(m_cnt));
  endtask

  // One clock: drive, take the edge, update the model, sample 1 ns later.
  task automatic cyc(input logic f, input logic s, input logic [127:0] w);
    flush           = f;
    counter_matched = s;
    rto_out         = w;
    @(posedge clk);
    model_edge(f, s, w);
    #1;
    flush           = 1'b0;
    counter_matched = 1'b0;
    rto_out         = '0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b0, '0);
      check_all(tag);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] lvl, input logic [7:0] wr,
                                      input logic [7:0] pl, input logic [15:0] width,
                                      input logic [63:0] ts);
    return {ts, 24'h0, width, pl, wr, lvl};
  endfunction

  typedef struct packed {
    logic [63:0] cmd;
    logic [7:0]  ttl;
    logic        busy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [127:0] w2, w4;
    logic [31:0]  cnt_saved;
    int           hi_cnt, busy_cnt;

    tbl[0] = '{64'h0000_0000_0000_FFA5, 8'hA5, 1'b0};  // plain level write
    tbl[1] = '{64'h0000_0000_0000_0FFF, 8'hAF, 1'b0};  // low nibble only
    tbl[2] = '{64'h0000_0000_0000_F000, 8'h0F, 1'b0};  // high nibble cleared
    tbl[3] = '{64'h0000_0000_00FF_FF3C, 8'h3C, 1'b0};  // pulse mask, width 0
    tbl[4] = '{64'h0000_0007_00FF_00FF, 8'h3C, 1'b0};  // write_mask 0: no effect
    tbl[5] = '{64'h0000_0000_00FF_0000, 8'h3C, 1'b0};  // pulse without write
    tbl[6] = '{64'hFFFF_FF00_0000_8181, 8'hBD, 1'b0};  // reserved bits ignored

    reset = 1'b0; flush = 1'b0; counter_matched = 1'b0; rto_out = '0;
    model_reset();
    @(negedge clk);
    chk("reset ttl_out", 128'(ttl_out), 128'(IDLE));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset override_error", 128'(override_error), 128'(0));
    chk("reset override_error_data", override_error_data, 128'(0));
    chk("reset command_count", 128'(command_count), 128'(0));
    reset = 1'b1;
    @(negedge clk);

    // Level-write latency
    cyc(1'b0, 1'b1, mk(8'hA5, 8'hFF, 8'h00, 16'd0, 64'h1));
    check_all("lvl");
    if (RET) begin
      chk("lvl latency hold", 128'(ttl_out), 128'(IDLE));
      idle(1, "lvl2");
    end
    chk("lvl ttl", 128'(ttl_out), 128'h A5);
    chk("lvl count", 128'(command_count), 128'd1);

    // Table of single-command vectors
    cyc(1'b1, 1'b0, '0);
    check_all("tbl flush");
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, {64'(i), tbl[i].cmd});
      check_all("tbl");
      if (LAT > 1) idle(LAT - 1, "tbl lat");
      chk($sformatf("tbl[%0d] ttl", i), 128'(ttl_out), 128'(tbl[i].ttl));
      chk($sformatf("tbl[%0d] busy", i), 128'(busy), 128'(tbl[i].busy));
    end

    // Pulse width 5 on ch0
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, mk(8'h01, 8'h01, 8'h01, 16'd5, 64'h2));
    check_all("pulse");
    hi_cnt = int'(ttl_out[0]); busy_cnt = int'(busy);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b0, '0);
      check_all("pulse run");
      hi_cnt += int'(ttl_out[0]); busy_cnt += int'(busy);
    end
    chk("pulse high cycles", 128'(hi_cnt), 128'd5);
    chk("pulse busy cycles", 128'(busy_cnt), 128'd5);
    chk("pulse end level", 128'(ttl_out), 128'h0);

    // Override of a long pulse on ch3
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, mk(8'h08, 8'h08, 8'h08, 16'd100, 64'h3));
    idle(39, "ovr wait");
    w2 = mk(8'h00, 8'h08, 8'h00, 16'd0, 64'hDEAD_BEEF_0000_0002);
    cyc(1'b0, 1'b1, w2);
    check_all("ovr");
    chk("ovr error", 128'(override_error), 128'd1);
    chk("ovr data", override_error_data, w2);
    if (LAT > 1) idle(LAT - 1, "ovr lat");
    chk("ovr ttl3", 128'(ttl_out[3]), 128'd0);
    chk("ovr busy", 128'(busy), 128'd0);
    cyc(1'b0, 1'b1, mk(8'h08, 8'h08, 8'h08, 16'd10, 64'h4));
    idle(3, "ovr3 wait");
    w4 = mk(8'h08, 8'h08, 8'h08, 16'd20, 64'h5);
    cyc(1'b0, 1'b1, w4);
    check_all("ovr3");
    chk("ovr3 data kept", override_error_data, w2);

    // Flush with simultaneous strobe during active pulses, error set
    cyc(1'b0, 1'b1, mk(8'h0F, 8'h0F, 8'h0F, 16'd50, 64'h6));
    idle(2, "fl pre");
    cnt_saved = m_cnt;
    cyc(1'b1, 1'b1, mk(8'hFF, 8'hFF, 8'hFF, 16'd9, 64'h7));
    check_all("flush");
    chk("flush ttl", 128'(ttl_out), 128'(IDLE));
    chk("flush busy", 128'(busy), 128'd0);
    chk("flush error", 128'(override_error), 128'd0);
    chk("flush count kept", 128'(command_count), 128'(cnt_saved));

    // Async reset mid-pulse, between edges
    cyc(1'b0, 1'b1, mk(8'h02, 8'h02, 8'h02, 16'd20, 64'h8));
    idle(3, "rst pre");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async rst ttl", 128'(ttl_out), 128'(IDLE));
    chk("async rst busy", 128'(busy), 128'd0);
    chk("async rst count", 128'(command_count), 128'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(25, "post rst");

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic f, s;
      logic [15:0] width;
      f     = ($urandom_range(63) == 0);
      s     = ($urandom_range(2) == 0);
      width = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(12, 1));
      cyc(f, s, mk(8'($urandom), 8'($urandom), 8'($urandom), width,
                   {32'($urandom), 32'($urandom)}));
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
